rally_tick_scheduler: RTL

Replaces the free-running divided clock with a single-cycle game-tick enable that sequences ball motion for one rally. Difficulty buttons are latched once at serve, and a serve delay precedes play. The tick period shortens as the rally accumulates hits. Ball/paddle logic runs on clk_in and advances only when tick is high.

---
 rtl/rally_tick_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rally_tick_scheduler.sv
// Purpose : single-cycle game-tick enable that sequences one rally: serve delay, then
//           ticks whose period shortens as the rally accumulates hits.
// Latency : tick is registered, high the cycle after a RALLY period expiry; no backpressure,
//           pause freezes the period counter and remembers SERVE/RALLY.
//
// Ports:
//   clk_in                 system clock
//   rst                    synchronous active-high reset, priority over all inputs
//   difficultyButton1/2    difficulty {MSB,LSB}, sampled only when a serve is accepted
//   serve_start            pulse, starts a rally from IDLE
//   hit / miss             pulses, paddle contact / ball lost (RALLY only)
//   pause                  level, freezes SERVE/RALLY
//   tick                   one-cycle game-advance enable
//   state                  0=IDLE 1=SERVE 2=RALLY 3=PAUSED
//   level                  difficulty latched at serve
//   speed_step             speed-ups applied this rally (saturates at 15)
//   period                 current tick period in clk_in cycles
//
// Optional feature macro: RALLY_SPEEDUP_EN (defined -> hit-driven period shortening;
// undefined -> hit ignored, period fixed per rally, speed_step tied to 0).

module rally_tick_scheduler #(
   parameter int BASE_LOG2    = 26,
   parameter int SERVE_TICKS  = 3,
   parameter int SPEEDUP_HITS = 4,
   parameter int MIN_PERIOD   = 2 ** (BASE_LOG2 - 1),
   parameter int PW           = BASE_LOG2 + 4
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          difficultyButton1,
   input  logic          difficultyButton2,
   input  logic          serve_start,
   input  logic          hit,
   input  logic          miss,
   input  logic          pause,
   output logic          tick,
   output logic [1:0]    state,
   output logic [1:0]    level,
   output logic [3:0]    speed_step,
   output logic [PW-1:0] period
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE  = 2'd1,
      RALLY  = 2'd2,
      PAUSED = 2'd3
   } stateT;

   localparam int SCW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;

   stateT         stateQ, stateNext;
   stateT         prevState, prevStateNext;
   logic [PW-1:0] counter, counterNext;
   logic [PW-1:0] periodNext;
   logic [PW-1:0] levelPeriod;
   logic [1:0]    levelNext;
   logic [1:0]    buttonLevel;
   logic [SCW-1:0] serveCount, serveCountNext;
   logic          tickNext;
   logic          expiry;
   logic          lastServeTick;

   assign state       = stateQ;
   assign buttonLevel = {difficultyButton1, difficultyButton2};
   assign levelPeriod = PW'(1) << (BASE_LOG2 + int'(buttonLevel));

   // ">=" rather than "==": after a speed-up shrinks the period the counter may
   // already be past the new end, and must expire at once instead of wrapping.
   assign expiry = ((stateQ == SERVE) || (stateQ == RALLY)) &&
                   (counter >= (period - PW'(1)));

   assign lastServeTick = (serveCount == SCW'(SERVE_TICKS - 1));

`ifdef RALLY_SPEEDUP_EN
   localparam int HCW = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS + 1) : 1;
   localparam logic [PW-1:0] MIN_P = PW'(MIN_PERIOD);

   logic [HCW-1:0] hitCount, hitCountNext;
   logic [3:0]     speedStep, speedStepNext;
   logic [PW-1:0]  reducedPeriod;
   logic [PW-1:0]  shrunkPeriod;

   // period - period/8 (truncating), clamped at the floor
   assign reducedPeriod = period - (period >> 3);
   assign shrunkPeriod  = (reducedPeriod < MIN_P) ? MIN_P : reducedPeriod;
   assign speed_step    = speedStep;
`else
   // Speed-up disabled: hit and the speed-up parameters have no effect.
   localparam int unusedSpeedupParams = MIN_PERIOD + SPEEDUP_HITS;
   logic unusedHit;
   assign unusedHit  = hit;
   assign speed_step = 4'd0;
`endif

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk_in) begin
      if (rst) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateNext;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      stateNext = stateQ;
      case (stateQ)
         IDLE: begin
            if (serve_start) stateNext = SERVE;
         end
         SERVE: begin
            if (pause)                        stateNext = PAUSED;
            else if (expiry && lastServeTick) stateNext = RALLY;
         end
         RALLY: begin
            // pause beats miss, miss beats hit
            if (pause)     stateNext = PAUSED;
            else if (miss) stateNext = IDLE;
         end
         PAUSED: begin
            if (!pause) stateNext = prevState;
         end
         default: stateNext = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs / datapath
   always_comb begin
      counterNext    = counter;
      tickNext       = 1'b0;
      serveCountNext = serveCount;
      levelNext      = level;
      periodNext     = period;
      prevStateNext  = prevState;
`ifdef RALLY_SPEEDUP_EN
      hitCountNext   = hitCount;
      speedStepNext  = speedStep;
`endif
      case (stateQ)
         IDLE: begin
            counterNext = '0;
            if (serve_start) begin
               levelNext      = buttonLevel;
               periodNext     = levelPeriod;
               serveCountNext = '0;
`ifdef RALLY_SPEEDUP_EN
               hitCountNext   = '0;
               speedStepNext  = 4'd0;
`endif
            end
         end
         SERVE: begin
            if (pause) begin
               prevStateNext = SERVE;
            end else if (expiry) begin
               counterNext    = '0;
               serveCountNext = serveCount + SCW'(1);
            end else begin
               counterNext = counter + PW'(1);
            end
         end
         RALLY: begin
            if (pause) begin
               // Expiry not consumed: it fires after resume with the counter intact.
               prevStateNext = RALLY;
            end else if (miss) begin
               counterNext = '0;
            end else begin
               tickNext    = expiry;
               counterNext = expiry ? '0 : counter + PW'(1);
`ifdef RALLY_SPEEDUP_EN
               if (hit) begin
                  if (hitCount == HCW'(SPEEDUP_HITS - 1)) begin
                     hitCountNext  = '0;
                     periodNext    = shrunkPeriod;
                     speedStepNext = (speedStep == 4'd15) ? 4'd15 : speedStep + 4'd1;
                  end else begin
                     hitCountNext = hitCount + HCW'(1);
                  end
               end
`endif
            end
         end
         PAUSED: begin
            // everything frozen; stateNext handles the return
         end
         default: begin
            counterNext = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         counter    <= '0;
         tick       <= 1'b0;
         serveCount <= '0;
         level      <= 2'd0;
         period     <= PW'(1) << BASE_LOG2;
         prevState  <= IDLE;
`ifdef RALLY_SPEEDUP_EN
         hitCount   <= '0;
         speedStep  <= 4'd0;
`endif
      end else begin
         counter    <= counterNext;
         tick       <= tickNext;
         serveCount <= serveCountNext;
         level      <= levelNext;
         period     <= periodNext;
         prevState  <= prevStateNext;
`ifdef RALLY_SPEEDUP_EN
         hitCount   <= hitCountNext;
         speedStep  <= speedStepNext;
`endif
      end
   end

endmodule
